// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator, its pixel source and the DAC.
// The master side is the generator; the slave side is the source/DAC pair.
interface vga_timing_gen_if #(
  parameter int COLOR_W = 10,
  parameter int CNT_W   = 12
) ();
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               request;
  logic [CNT_W-1:0]   current_x;
  logic [CNT_W-1:0]   current_y;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_blank;
  logic               vga_clock;
  logic               line_end;
  logic               frame_end;

  modport master (
    input  r, g, b,
    output request, current_x, current_y,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_clock,
    output line_end, frame_end
  );

  modport slave (
    output r, g, b,
    input  request, current_x, current_y,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_clock,
    input  line_end, frame_end
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator with look-ahead pixel requests and
// a blanking gate on the pixel path to the DAC.
module vga_timing_gen #(
  parameter int COLOR_W  = 10,
  parameter int CNT_W    = 12,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACT    = 640,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACT    = 480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 1
) (
  input  logic             clk27,
  input  logic             rst27,
  vga_timing_gen_if.master vga
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_ACT;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_BLANK);
  localparam logic [CNT_W-1:0] REQ_LO   = CNT_W'(H_BLANK - REQ_LEAD);
  localparam logic [CNT_W-1:0] REQ_HI   = CNT_W'(H_TOTAL - REQ_LEAD);
  localparam logic [CNT_W-1:0] LEAD     = CNT_W'(REQ_LEAD);
  localparam logic [COLOR_W-1:0] DARK   = '0;

  function automatic logic in_span(input logic [CNT_W-1:0] c, lo, hi);
    return (c >= lo) && (c < hi);
  endfunction

  logic [CNT_W-1:0] h, v, h_nxt, v_nxt;

  logic             hs_p0, vs_p0, blank_p0, vld_p0, le_p0, fe_p0;
  logic [CNT_W-1:0] x_p0, y_p0;
  logic             hs_p1, vs_p1, blank_p1, vld_p1, le_p1, fe_p1;
  logic [CNT_W-1:0] x_p1, y_p1;

  always_comb begin
    h_nxt = h + CNT_W'(1);
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + CNT_W'(1);
    end
  end

  // p0: decode from the counter values the next edge will load, so every
  // registered output lines up with h/v with no extra latency.
  always_comb begin
    hs_p0    = in_span(h_nxt, HS_LO, HS_HI) ? HS_POL : ~HS_POL;
    vs_p0    = in_span(v_nxt, VS_LO, VS_HI) ? VS_POL : ~VS_POL;
    blank_p0 = (h_nxt >= H_ACT_LO) && (v_nxt >= V_ACT_LO);
    vld_p0   = (v_nxt >= V_ACT_LO) && in_span(h_nxt, REQ_LO, REQ_HI);
    x_p0     = '0;
    y_p0     = '0;
    if (vld_p0) begin
      x_p0 = h_nxt + LEAD - H_ACT_LO;
      y_p0 = v_nxt - V_ACT_LO;
    end
    le_p0    = (h_nxt == H_LAST);
    fe_p0    = le_p0 && (v_nxt == V_LAST);
  end

  // p1: counters and all timing outputs share one register stage.
  always_ff @(posedge clk27) begin
    if (rst27) begin
      h        <= '0;
      v        <= '0;
      hs_p1    <= ~HS_POL;
      vs_p1    <= ~VS_POL;
      blank_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      le_p1    <= 1'b0;
      fe_p1    <= 1'b0;
    end else begin
      h        <= h_nxt;
      v        <= v_nxt;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      blank_p1 <= blank_p0;
      vld_p1   <= vld_p0;
      x_p1     <= x_p0;
      y_p1     <= y_p0;
      le_p1    <= le_p0;
      fe_p1    <= fe_p0;
    end
  end

  assign vga.request   = vld_p1;
  assign vga.current_x = x_p1;
  assign vga.current_y = y_p1;
  assign vga.vga_hs    = hs_p1;
  assign vga.vga_vs    = vs_p1;
  assign vga.vga_blank = blank_p1;
  assign vga.line_end  = le_p1;
  assign vga.frame_end = fe_p1;
  assign vga.vga_clock = ~clk27;

  // The source already aligned its data to the display cycle; only gate it.
  assign vga.vga_r = blank_p1 ? vga.r : DARK;
  assign vga.vga_g = blank_p1 ? vga.g : DARK;
  assign vga.vga_b = blank_p1 ? vga.b : DARK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (defaults, 3-clock lead, small
// active-high instance) checked against a raster model driven by elapsed time.
module tb_vga_timing_gen;
  localparam int CW = 10;
  localparam int NW = 12;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          blank;
    logic          req;
    logic [NW-1:0] x;
    logic [NW-1:0] y;
    logic          le;
    logic          fe;
  } obs_t;

  logic clk27 = 1'b0;
  logic rst_d = 1'b1;
  logic rst_l = 1'b1;
  logic rst_s = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  int k_d = 0;
  int k_l = 0;
  int k_s = 0;
  logic [CW-1:0] pd1 = '0;
  logic [CW-1:0] pl1 = '0;
  logic [CW-1:0] pl2 = '0;
  logic [CW-1:0] pl3 = '0;
  logic [CW-1:0] rnd_s = '0;

  always #5 clk27 = ~clk27;

  vga_timing_gen_if #(.COLOR_W(CW), .CNT_W(NW)) if_d ();
  vga_timing_gen_if #(.COLOR_W(CW), .CNT_W(NW)) if_l ();
  vga_timing_gen_if #(.COLOR_W(CW), .CNT_W(NW)) if_s ();

  vga_timing_gen #(.REQ_LEAD(1)) dut_d (.clk27(clk27), .rst27(rst_d), .vga(if_d));
  vga_timing_gen #(.REQ_LEAD(3)) dut_l (.clk27(clk27), .rst27(rst_l), .vga(if_l));
  vga_timing_gen #(
    .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .H_ACT(4),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(0)
  ) dut_s (.clk27(clk27), .rst27(rst_s), .vga(if_s));

  // Elapsed edges since the last reset edge, and pixel sources that echo the
  // requested x after each instance's lead (random filler when not requested).
  always @(posedge clk27) begin
    k_d <= rst_d ? 0 : k_d + 1;
    k_l <= rst_l ? 0 : k_l + 1;
    k_s <= rst_s ? 0 : k_s + 1;
    pd1 <= if_d.request ? if_d.current_x[CW-1:0] : CW'($urandom);
    pl1 <= if_l.request ? if_l.current_x[CW-1:0] : CW'($urandom);
    pl2 <= pl1;
    pl3 <= pl2;
  end
  always @(negedge clk27) rnd_s <= CW'($urandom);

  assign if_d.r = pd1;
  assign if_d.g = pd1 ^ 10'h2aa;
  assign if_d.b = ~pd1;
  assign if_l.r = pl3;
  assign if_l.g = pl3 ^ 10'h155;
  assign if_l.b = ~pl3;
  assign if_s.r = if_s.request ? if_s.current_x[CW-1:0] : rnd_s;
  assign if_s.g = ~if_s.r;
  assign if_s.b = rnd_s;

  // Raster model: position from elapsed time, outputs from region rules.
  function automatic obs_t model(input int which, input int k);
    int hf, hsw, hb, ha, vf, vsw, vb, va, lead, hbl, vbl, ht, vt, p, h, v;
    bit hp, vp;
    obs_t e;
    if (which == 2) begin
      hf = 2; hsw = 2; hb = 2; ha = 4; vf = 1; vsw = 1; vb = 1; va = 3;
      hp = 1'b1; vp = 1'b1; lead = 0;
    end else begin
      hf = 16; hsw = 96; hb = 48; ha = 640; vf = 10; vsw = 2; vb = 33; va = 480;
      hp = 1'b0; vp = 1'b0; lead = (which == 1) ? 3 : 1;
    end
    hbl = hf + hsw + hb;
    vbl = vf + vsw + vb;
    ht = hbl + ha;
    vt = vbl + va;
    p = k % (ht * vt);
    h = p % ht;
    v = p / ht;
    e.hs = (h >= hf && h < hf + hsw) ? hp : !hp;
    e.vs = (v >= vf && v < vf + vsw) ? vp : !vp;
    e.blank = (h >= hbl) && (v >= vbl);
    e.req = (v >= vbl) && (h + lead >= hbl) && (h + lead < ht);
    e.x = e.req ? NW'(h + lead - hbl) : '0;
    e.y = e.req ? NW'(v - vbl) : '0;
    e.le = (h == ht - 1);
    e.fe = (h == ht - 1) && (v == vt - 1);
    return e;
  endfunction

  function automatic int hpos(input int which, input int k);
    return k % ((which == 2) ? 10 : 800);
  endfunction

  function automatic int vpos(input int which, input int k);
    return (which == 2) ? (k / 10) % 6 : (k / 800) % 525;
  endfunction

  function automatic int hblank_of(input int which);
    return (which == 2) ? 6 : 160;
  endfunction

  function automatic logic [3*CW-1:0] exp_pix(input int which, input int k,
                                              input logic [CW-1:0] g_in, b_in);
    obs_t e;
    e = model(which, k);
    if (!e.blank) return '0;
    return {CW'(hpos(which, k) - hblank_of(which)), g_in, b_in};
  endfunction

  function automatic obs_t obs_of(input int which);
    obs_t o;
    case (which)
      0: o = {if_d.vga_hs, if_d.vga_vs, if_d.vga_blank, if_d.request,
              if_d.current_x, if_d.current_y, if_d.line_end, if_d.frame_end};
      1: o = {if_l.vga_hs, if_l.vga_vs, if_l.vga_blank, if_l.request,
              if_l.current_x, if_l.current_y, if_l.line_end, if_l.frame_end};
      default: o = {if_s.vga_hs, if_s.vga_vs, if_s.vga_blank, if_s.request,
                    if_s.current_x, if_s.current_y, if_s.line_end, if_s.frame_end};
    endcase
    return o;
  endfunction

  function automatic logic [3*CW-1:0] pix_of(input int which);
    case (which)
      0: return {if_d.vga_r, if_d.vga_g, if_d.vga_b};
      1: return {if_l.vga_r, if_l.vga_g, if_l.vga_b};
      default: return {if_s.vga_r, if_s.vga_g, if_s.vga_b};
    endcase
  endfunction

  task automatic step();
    @(negedge clk27);
    #1;
  endtask

  task automatic test_reset();
    int n;
    obs_t rd, rs;
    rd = '0;
    rd.hs = 1'b1;
    rd.vs = 1'b1;
    rs = '0;
    repeat (3) step();
    rst_d = 1'b0; rst_l = 1'b0; rst_s = 1'b0;
    repeat ($urandom_range(300, 700)) step();
    rst_d = 1'b1; rst_l = 1'b1; rst_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if ({obs_of(0), pix_of(0)} !== {rd, 30'd0})
        $display("FAIL reset_default cycle %0d: got %h want %h", i, {obs_of(0), pix_of(0)}, {rd, 30'd0});
      else n_pass++;
      n_total++;
      if ({obs_of(2), pix_of(2)} !== {rs, 30'd0})
        $display("FAIL reset_small cycle %0d: got %h want %h", i, {obs_of(2), pix_of(2)}, {rs, 30'd0});
      else n_pass++;
    end
    rst_d = 1'b0; rst_l = 1'b0; rst_s = 1'b0;
    step();
    n_total++;
    if (obs_of(0) !== model(0, 1))
      $display("FAIL first_edge_default: got %h want %h", obs_of(0), model(0, 1));
    else n_pass++;
    n_total++;
    if (obs_of(2) !== model(2, 1))
      $display("FAIL first_edge_small: got %h want %h", obs_of(2), model(2, 1));
    else n_pass++;
    n = 1;
    while (if_d.vga_hs !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    n_total++;
    if (n != 16) $display("FAIL first_hs_edge: got h=%0d want h=16", n);
    else n_pass++;
    n_total++;
    if (if_d.vga_clock !== 1'b1) $display("FAIL vga_clock_low_phase: got %b want 1", if_d.vga_clock);
    else n_pass++;
    @(posedge clk27);
    #1;
    n_total++;
    if (if_d.vga_clock !== 1'b0) $display("FAIL vga_clock_high_phase: got %b want 0", if_d.vga_clock);
    else n_pass++;
    step();
  endtask

  task automatic test_default_vertical();
    int err = 0, vs_cnt = 0, vs_first = -1, vs_last = -1;
    int le_cnt = 0, fe_cnt = 0, bl_cnt = 0, guard = 0;
    while (k_d < 45 * 800 && guard < 40000) begin
      if (obs_of(0) !== model(0, k_d)) begin
        if (err == 0) $display("first raster diff k=%0d got %h want %h", k_d, obs_of(0), model(0, k_d));
        err++;
      end
      if (obs_of(1) !== model(1, k_l)) err++;
      if (if_d.vga_vs === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = vpos(0, k_d);
        vs_last = vpos(0, k_d);
      end
      if (if_d.line_end === 1'b1) le_cnt++;
      if (if_d.frame_end === 1'b1) fe_cnt++;
      if (if_d.vga_blank === 1'b1) bl_cnt++;
      step();
      guard++;
    end
    n_total++;
    if (k_d != 45 * 800) $display("FAIL vertical_budget: reached k=%0d want %0d", k_d, 45 * 800);
    else n_pass++;
    n_total++;
    if (err != 0) $display("FAIL vertical_raster: got %0d mismatching cycles want 0", err);
    else n_pass++;
    n_total++;
    if (vs_cnt != 1600 || vs_first != 10 || vs_last != 11)
      $display("FAIL vs_window: got %0d clocks lines %0d..%0d want 1600 lines 10..11", vs_cnt, vs_first, vs_last);
    else n_pass++;
    n_total++;
    if (le_cnt != 45) $display("FAIL line_end_count: got %0d want 45", le_cnt);
    else n_pass++;
    n_total++;
    if (fe_cnt != 0 || bl_cnt != 0)
      $display("FAIL vblank_quiet: got frame_end=%0d blank=%0d want 0 0", fe_cnt, bl_cnt);
    else n_pass++;
  endtask

  task automatic test_default_horizontal();
    int err = 0, hs_cnt = 0, hs_first = -1, bl_cnt = 0, bl_first = -1, h;
    repeat (800) begin
      h = hpos(0, k_d);
      if (obs_of(0) !== model(0, k_d)) err++;
      if (pix_of(0) !== exp_pix(0, k_d, if_d.g, if_d.b)) err++;
      if (if_d.vga_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h;
      end
      if (if_d.vga_blank === 1'b1) begin
        bl_cnt++;
        if (bl_first < 0) bl_first = h;
      end
      step();
    end
    n_total++;
    if (hs_cnt != 96 || hs_first != 16)
      $display("FAIL hs_width: got %0d from h=%0d want 96 from h=16", hs_cnt, hs_first);
    else n_pass++;
    n_total++;
    if (bl_cnt != 640 || bl_first != 160)
      $display("FAIL blank_width: got %0d from h=%0d want 640 from h=160", bl_cnt, bl_first);
    else n_pass++;
    n_total++;
    if (err != 0) $display("FAIL default_active_line: got %0d mismatches want 0", err);
    else n_pass++;
  endtask

  task automatic test_request_lead();
    int err = 0, rq_h = -1, rq_x = -1, rq_y = -1, last_h = -1, h;
    repeat (800) begin
      h = hpos(1, k_l);
      if (obs_of(1) !== model(1, k_l)) err++;
      if (pix_of(1) !== exp_pix(1, k_l, if_l.g, if_l.b)) err++;
      if (if_l.request === 1'b1 && rq_h < 0) begin
        rq_h = h;
        rq_x = int'(if_l.current_x);
        rq_y = int'(if_l.current_y);
      end
      if (if_l.request === 1'b1 && if_l.current_x == 12'd639) last_h = h;
      step();
    end
    n_total++;
    if (rq_h != 157 || rq_x != 0 || rq_y != 0)
      $display("FAIL lead_first_request: got h=%0d x=%0d y=%0d want h=157 x=0 y=0", rq_h, rq_x, rq_y);
    else n_pass++;
    n_total++;
    if (last_h != 796) $display("FAIL lead_last_pixel: got h=%0d want h=796", last_h);
    else n_pass++;
    n_total++;
    if (err != 0) $display("FAIL lead_echo_line: got %0d mismatches want 0", err);
    else n_pass++;
  endtask

  task automatic test_small();
    int err = 0, hs_hi = 0, hs_bad = 0, vs_hi = 0, bl_cnt = 0, le_cnt = 0;
    int fe_cnt = 0, fe_prev = -1, period = -1, both = 0, h;
    repeat (180) begin
      h = hpos(2, k_s);
      if (obs_of(2) !== model(2, k_s)) err++;
      if (pix_of(2) !== exp_pix(2, k_s, if_s.g, if_s.b)) err++;
      if (if_s.vga_hs === 1'b1) begin
        hs_hi++;
        if (h < 2 || h > 3) hs_bad++;
      end
      if (if_s.vga_vs === 1'b1) vs_hi++;
      if (if_s.vga_blank === 1'b1) bl_cnt++;
      if (if_s.line_end === 1'b1) le_cnt++;
      if (if_s.frame_end === 1'b1) begin
        fe_cnt++;
        if (if_s.line_end === 1'b1 && h == 9 && vpos(2, k_s) == 5) both++;
        if (fe_prev >= 0) period = k_s - fe_prev;
        fe_prev = k_s;
      end
      step();
    end
    n_total++;
    if (hs_hi != 36 || hs_bad != 0)
      $display("FAIL small_hs: got %0d high (%0d outside h=2..3) want 36 (0)", hs_hi, hs_bad);
    else n_pass++;
    n_total++;
    if (vs_hi != 30) $display("FAIL small_vs: got %0d high clocks want 30", vs_hi);
    else n_pass++;
    n_total++;
    if (bl_cnt != 36) $display("FAIL small_blank: got %0d want 36", bl_cnt);
    else n_pass++;
    n_total++;
    if (le_cnt != 18) $display("FAIL small_line_end: got %0d want 18", le_cnt);
    else n_pass++;
    n_total++;
    if (fe_cnt != 3 || both != 3)
      $display("FAIL small_wrap: got %0d frame_end (%0d at (9,5) with line_end) want 3 (3)", fe_cnt, both);
    else n_pass++;
    n_total++;
    if (period != 60) $display("FAIL small_period: got %0d want 60", period);
    else n_pass++;
    n_total++;
    if (err != 0) $display("FAIL small_raster: got %0d mismatches want 0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_active();
    int n = 0, noisy = 0, hold;
    while (if_d.vga_blank !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    repeat ($urandom_range(1, 100)) step();
    n_total++;
    if (if_d.request !== 1'b1 || if_d.vga_r === '0)
      $display("FAIL mid_active_setup: got request=%b vga_r=%0d want 1 and nonzero", if_d.request, if_d.vga_r);
    else n_pass++;
    rst_d = 1'b1;
    step();
    n_total++;
    if (if_d.vga_r !== '0 || if_d.request !== 1'b0 || if_d.vga_blank !== 1'b0)
      $display("FAIL mid_active_reset: got vga_r=%0d request=%b blank=%b want 0 0 0",
               if_d.vga_r, if_d.request, if_d.vga_blank);
    else n_pass++;
    rst_d = 1'b0;
    n = 0;
    while (if_s.vga_blank !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    rst_s = 1'b1;
    hold = $urandom_range(1, 4);
    for (int i = 0; i < hold; i++) begin
      step();
      if ({obs_of(2), pix_of(2)} !== '0) noisy++;
    end
    n_total++;
    if (noisy != 0) $display("FAIL small_reset_hold: got %0d noisy cycles want 0", noisy);
    else n_pass++;
    rst_s = 1'b0;
    step();
    n = 1;
    while (if_s.frame_end !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_total++;
    if (n != 59) $display("FAIL small_first_frame_end: got %0d clocks want 59", n);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int err = 0;
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 150)) begin
        if (obs_of(2) !== model(2, k_s)) err++;
        if (pix_of(2) !== exp_pix(2, k_s, if_s.g, if_s.b)) err++;
        step();
      end
      rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        step();
        if (obs_of(2) !== model(2, k_s)) err++;
        if (pix_of(2) !== '0) err++;
      end
      rst_s = 1'b0;
    end
    n_total++;
    if (err != 0) $display("FAIL random_resets: got %0d mismatches want 0", err);
    else n_pass++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_vertical();
    fork
      test_default_horizontal();
      test_request_lead();
    join
    test_small();
    test_reset_mid_active();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
